prog_channels_multi: RTL
========================

Name: prog_channels_multi

Overview:
- Parametrised successor to the channel-FPGA serial configurator; drives PROGRAM_B, CCLK and DIN to NCHAN channel FPGAs from the SPI-flash bitstream stream.
- Adds a per-channel enable mask, INITB and DONE timeouts, automatic retry, and a status/error interface readable over IPbus.
- Sits between the IPbus control registers and spi_flash_intf.

Parameters:
- NCHAN, 5, number of channel FPGAs (1..16).
- PROG_CYCLES, 16, clk cycles PROGRAM_B held low after all enabled INITB are low (≥250 ns at bench clock).
- INIT_TIMEOUT, 65536, max clk cycles waiting in each INITB phase.
- DONE_TIMEOUT, 1048576, max clk cycles waiting for DONE after end_bitstream.
- MAX_RETRIES, 2, extra attempts after the first failure (0..7).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  IPbus start level; rising edge triggers
- chan_mask  in  NCHAN  1 = channel participates; sampled on accepted start
- c_progb  out  1  PROGRAM_B to all channels
- c_clk  out  1  CCLK, equals inverted clk
- c_din  out  1  serial configuration data
- initb  in  NCHAN  INIT_B from each channel (async)
- prog_done  in  NCHAN  DONE from each channel (async)
- bitstream  in  1  serial data from spi_flash_intf
- end_bitstream  in  1  last bit delivered
- prog_chan_in_progress  out  1  to spi_flash_intf
- store_flash_command  out  1  1-cycle pulse to spi_flash_intf
- read_bitstream  out  1  read enable to spi_flash_intf
- busy  out  1  state not IDLE/DONE/ERROR
- done_ok  out  1  sticky success
- error  out  1  sticky failure
- err_code  out  3  0 none, 1 INITB-low timeout, 2 INITB-high timeout, 3 DONE timeout, 4 CRC, 5 empty mask
- err_chan  out  NCHAN  enabled channels failing the timed-out condition at time of failure
- retry_count  out  3  retries consumed in current/last run

Behaviour:
- Reset: c_progb=1, c_din=1, all strobes 0, busy=0, done_ok=0, error=0, err_code=0, err_chan=0, retry_count=0, state IDLE, counters 0.
- initb/prog_done pass through 2-flop synchronisers; all decisions use synchronised values. Masked-off channels are treated as satisfying every condition.
- start is edge-detected (registered previous value). Accepted only in IDLE, DONE or ERROR; the edge clears done_ok, error, err_code, err_chan and retry_count, and latches chan_mask. Edges in other states are ignored.
- Latched mask == 0: go to ERROR with err_code=5, no flash traffic.
- IDLE: outputs idle; on accepted edge go to STORE_CMD.
- STORE_CMD (1 cycle): store_flash_command=1, prog_chan_in_progress=1; go to PROG_LOW.
- PROG_LOW: c_progb=0, counter clears. When all enabled INITB are 0, go to PROG_HOLD. If the counter reaches INIT_TIMEOUT, fail with code 1.
- PROG_HOLD: c_progb=0 for exactly PROG_CYCLES cycles, then go to WAIT_INIT.
- WAIT_INIT: c_progb=1. When all enabled INITB are 1, go to LOAD. If INIT_TIMEOUT is reached, fail with code 2.
- LOAD: read_bitstream=1, c_din registered from bitstream each cycle (1-cycle latency). end_bitstream moves to WAIT_DONE the next cycle.
- WAIT_DONE: c_din=1. When all enabled DONE are 1, go to DONE_ST (done_ok=1). If DONE_TIMEOUT is reached, fail with code 3.
- Fail: err_chan is captured. If retry_count < MAX_RETRIES, increment it and go to STORE_CMD, with the flash re-commanded and PROGRAM_B re-pulsed. Otherwise go to ERROR with error=1.
- DONE_ST/ERROR: prog_chan_in_progress=0, c_progb=1; held until the next accepted start or reset.
- prog_chan_in_progress=1 in every state except IDLE, DONE_ST and ERROR.
- Timeout counters are sized $clog2(max timeout)+1 bits and clear on every state entry.
- Reset mid-operation returns to IDLE the same cycle with c_progb=1. spi_flash_intf sees read_bitstream drop.

Optional Feature:
- PROG_CHAN_CRC_CHECK_EN defined: in LOAD and WAIT_DONE, any enabled synchronised INITB=0 is a fail with code 4 (retry rules apply). err_chan holds the channels with INITB low.
- Undefined: INITB is ignored after WAIT_INIT and code 4 is never produced.

Test Plan:
- NCHAN=5, mask=5'b11111, model drops INITB 3 cycles after PROGRAM_B low, raises DONE 10 cycles after end_bitstream -> single store pulse, PROGRAM_B low for ≥16 cycles, c_din replicates bitstream delayed 1 cycle, done_ok=1, retry_count=0.
- mask=5'b00101, channels 1,3,4 stuck INITB high -> completes normally, done_ok=1.
- Channel 2 DONE never rises, MAX_RETRIES=2, DONE_TIMEOUT=64 -> three store pulses, error=1, err_code=3, err_chan=5'b00100, retry_count=2.
- mask=0 with a start edge -> error=1, err_code=5, store_flash_command never asserted.
- Start held high after DONE_ST, then reset asserted mid-LOAD -> no restart without a new edge; reset gives IDLE, c_progb=1, read_bitstream=0 on the next cycle.
- With PROG_CHAN_CRC_CHECK_EN, channel 0 INITB pulled low mid-LOAD, MAX_RETRIES=0 -> error=1, err_code=4, err_chan=5'b00001.

Source files
------------

// File: rtl/prog_channels_multi_if.sv
// Signal bundle between the channel-FPGA configurator, the channel FPGAs and spi_flash_intf.
// master = configurator side, slave = channels/flash/control-register side.
interface prog_channels_multi_if #(
   parameter int NCHAN = 5
);
   // Flash stream: while read_bitstream is high, spi_flash_intf presents one new bit on
   // bitstream every clk cycle with no back-pressure; end_bitstream marks the final bit.
   logic             start;
   logic [NCHAN-1:0] chan_mask;
   logic             c_progb;
   logic             c_clk;
   logic             c_din;
   logic [NCHAN-1:0] initb;
   logic [NCHAN-1:0] prog_done;
   logic             bitstream;
   logic             end_bitstream;
   logic             prog_chan_in_progress;
   logic             store_flash_command;
   logic             read_bitstream;
   logic             busy;
   logic             done_ok;
   logic             error;
   logic [2:0]       err_code;
   logic [NCHAN-1:0] err_chan;
   logic [2:0]       retry_count;

   modport master (
      input  start, chan_mask, initb, prog_done, bitstream, end_bitstream,
      output c_progb, c_clk, c_din, prog_chan_in_progress, store_flash_command,
             read_bitstream, busy, done_ok, error, err_code, err_chan, retry_count
   );

   modport slave (
      output start, chan_mask, initb, prog_done, bitstream, end_bitstream,
      input  c_progb, c_clk, c_din, prog_chan_in_progress, store_flash_command,
             read_bitstream, busy, done_ok, error, err_code, err_chan, retry_count
   );
endinterface

// File: rtl/prog_channels_multi.sv
// Serial configurator for NCHAN channel FPGAs with enable mask, timeouts, retry and status.
// Optional: define PROG_CHAN_CRC_CHECK_EN to fail on INITB low during LOAD/WAIT_DONE (code 4).
module prog_channels_multi #(
   parameter int NCHAN        = 5,
   parameter int PROG_CYCLES  = 16,
   parameter int INIT_TIMEOUT = 65536,
   parameter int DONE_TIMEOUT = 1048576,
   parameter int MAX_RETRIES  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   prog_channels_multi_if.master bus,
   output logic [3:0]           state_dbg
);

   localparam int MAX_TO_A = (INIT_TIMEOUT > DONE_TIMEOUT) ? INIT_TIMEOUT : DONE_TIMEOUT;
   localparam int MAX_TO   = (MAX_TO_A > PROG_CYCLES) ? MAX_TO_A : PROG_CYCLES;
   localparam int CW       = $clog2(MAX_TO) + 1;

   localparam logic [CW-1:0] INIT_LAST = CW'(INIT_TIMEOUT - 1);
   localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TIMEOUT - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(PROG_CYCLES - 1);
   localparam logic [2:0]    MAX_R3    = 3'(MAX_RETRIES);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_STORE_CMD = 4'd1,
      S_PROG_LOW  = 4'd2,
      S_PROG_HOLD = 4'd3,
      S_WAIT_INIT = 4'd4,
      S_LOAD      = 4'd5,
      S_WAIT_DONE = 4'd6,
      S_DONE      = 4'd7,
      S_ERROR     = 4'd8
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [NCHAN-1:0] initb_meta, initb_s, done_meta, done_s;
   logic [NCHAN-1:0] mask_q;
   logic             start_q;
   logic             c_din_q;
   logic             done_ok_q, error_q;
   logic [2:0]       err_code_q, retry_q;
   logic [NCHAN-1:0] err_chan_q;

   logic             start_acc;
   logic             all_low, all_high, all_done;
   logic             timed;
   logic             fail;
   logic [2:0]       fail_code;
   logic [NCHAN-1:0] fail_chan;

   // INIT_B and DONE come straight from the channel FPGAs, unrelated to clk
   always_ff @(posedge clk) begin
      if (reset) begin
         initb_meta <= '0;
         initb_s    <= '0;
         done_meta  <= '0;
         done_s     <= '0;
         start_q    <= 1'b0;
      end else begin
         initb_meta <= bus.initb;
         initb_s    <= initb_meta;
         done_meta  <= bus.prog_done;
         done_s     <= done_meta;
         start_q    <= bus.start;
      end
   end

   // Masked-off channels always satisfy the condition being waited for
   assign all_low  = ((initb_s & mask_q) == '0);
   assign all_high = &(initb_s | ~mask_q);
   assign all_done = &(done_s | ~mask_q);

   assign start_acc = bus.start && !start_q &&
                      (state == S_IDLE || state == S_DONE || state == S_ERROR);

`ifdef PROG_CHAN_CRC_CHECK_EN
   logic crc_bad;
   assign crc_bad = ((~initb_s & mask_q) != '0);
`endif

   assign timed = (state == S_PROG_LOW) || (state == S_PROG_HOLD) ||
                  (state == S_WAIT_INIT) || (state == S_WAIT_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fail      = 1'b0;
      fail_code = 3'd0;
      fail_chan = '0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start_acc) begin
               state_nxt = (bus.chan_mask == '0) ? S_ERROR : S_STORE_CMD;
            end
         end
         S_STORE_CMD: state_nxt = S_PROG_LOW;
         S_PROG_LOW: begin
            if (all_low) begin
               state_nxt = S_PROG_HOLD;
            end else if (cnt == INIT_LAST) begin
               fail      = 1'b1;
               fail_code = 3'd1;
               fail_chan = initb_s & mask_q;
            end
         end
         S_PROG_HOLD: begin
            if (cnt == HOLD_LAST) begin
               state_nxt = S_WAIT_INIT;
            end
         end
         S_WAIT_INIT: begin
            if (all_high) begin
               state_nxt = S_LOAD;
            end else if (cnt == INIT_LAST) begin
               fail      = 1'b1;
               fail_code = 3'd2;
               fail_chan = ~initb_s & mask_q;
            end
         end
         S_LOAD: begin
`ifdef PROG_CHAN_CRC_CHECK_EN
            if (crc_bad) begin
               fail      = 1'b1;
               fail_code = 3'd4;
               fail_chan = ~initb_s & mask_q;
            end else
`endif
            if (bus.end_bitstream) begin
               state_nxt = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (all_done) begin
               state_nxt = S_DONE;
`ifdef PROG_CHAN_CRC_CHECK_EN
            end else if (crc_bad) begin
               fail      = 1'b1;
               fail_code = 3'd4;
               fail_chan = ~initb_s & mask_q;
`endif
            end else if (cnt == DONE_LAST) begin
               fail      = 1'b1;
               fail_code = 3'd3;
               fail_chan = ~done_s & mask_q;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (fail) begin
         state_nxt = (retry_q < MAX_R3) ? S_STORE_CMD : S_ERROR;
      end
   end

   // Single counter serves the hold time and all three timeouts; it restarts on every state entry
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (state_nxt != state || !timed) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q     <= '0;
         done_ok_q  <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= 3'd0;
         err_chan_q <= '0;
         retry_q    <= 3'd0;
      end else if (start_acc) begin
         mask_q     <= bus.chan_mask;
         done_ok_q  <= 1'b0;
         err_chan_q <= '0;
         retry_q    <= 3'd0;
         error_q    <= (bus.chan_mask == '0);
         err_code_q <= (bus.chan_mask == '0) ? 3'd5 : 3'd0;
      end else begin
         if (fail) begin
            err_code_q <= fail_code;
            err_chan_q <= fail_chan;
            if (retry_q < MAX_R3) begin
               retry_q <= retry_q + 3'd1;
            end else begin
               error_q <= 1'b1;
            end
         end
         if (state_nxt == S_DONE && state != S_DONE) begin
            done_ok_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         c_din_q <= 1'b1;
      end else begin
         c_din_q <= (state == S_LOAD) ? bus.bitstream : 1'b1;
      end
   end

   // Strobes decode directly from state so a reset releases PROGRAM_B and read enable at once
   assign bus.c_progb               = !(state == S_PROG_LOW || state == S_PROG_HOLD);
   assign bus.c_clk                 = ~clk;
   assign bus.c_din                 = c_din_q;
   assign bus.store_flash_command   = (state == S_STORE_CMD);
   assign bus.read_bitstream        = (state == S_LOAD);
   assign bus.prog_chan_in_progress = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
   assign bus.busy                  = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
   assign bus.done_ok               = done_ok_q;
   assign bus.error                 = error_q;
   assign bus.err_code              = err_code_q;
   assign bus.err_chan              = err_chan_q;
   assign bus.retry_count           = retry_q;
   assign state_dbg                 = state;

endmodule
